// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch pipeline and its neighbours.
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    // addi x0,x0,0; kept for a later flush-to-NOP variant of the IF/ID register
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/en_clr_reg.sv
// Register with async reset to RST_VAL, sync clear to zero, and load enable; one cycle latency.
// Priority: reset, clear, enable; with enable low and clear low the value holds.
module en_clr_reg #(
    parameter int             W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_pipe.sv
// RV32 fetch stage: PC register, next-PC select, and IF/ID register; instruction reaches Decode one cycle after fetch.
// StallF holds the PC (dropping any redirect), StallD holds IF/ID, FlushD zeroes IF/ID and beats StallD.
module fetch_pc_pipe #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    logic [XLEN-1:0] pc_next;

    // Wraps modulo 2^XLEN; carry out is discarded.
    assign PCPlus4F = PCF + XLEN'(4);
    assign pc_next  = PCSrcE ? PCTargetE : PCPlus4F;

    en_clr_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (~StallF),
        .d     (pc_next),
        .q     (PCF)
    );

    en_clr_reg #(.W(XLEN), .RST_VAL('0)) u_instr_d (
        .clk   (clk),
        .reset (reset),
        .clr   (FlushD),
        .en    (~StallD),
        .d     (InstrF),
        .q     (InstrD)
    );

    en_clr_reg #(.W(XLEN), .RST_VAL('0)) u_pc_d (
        .clk   (clk),
        .reset (reset),
        .clr   (FlushD),
        .en    (~StallD),
        .d     (PCF),
        .q     (PCD)
    );

    en_clr_reg #(.W(XLEN), .RST_VAL('0)) u_pcplus4_d (
        .clk   (clk),
        .reset (reset),
        .clr   (FlushD),
        .en    (~StallD),
        .d     (PCPlus4F),
        .q     (PCPlus4D)
    );

endmodule

// File: tb/tb_fetch_pc_pipe.sv
// Randomized and directed bench for fetch_pc_pipe against a cycle-level behavioural model.
module tb_fetch_pc_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0, InstrF = '0;
    logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: what Fetch and Decode should be holding.
    logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d;

    fetch_pc_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc      = 32'h0;
        m_instr_d = 32'h0;
        m_pc_d    = 32'h0;
        m_pc4_d   = 32'h0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven, then let the DUT settle.
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_pcd, n_pc4;
        n_pc    = StallF ? m_pc : (PCSrcE ? PCTargetE : m_pc + 32'd4);
        n_instr = m_instr_d;
        n_pcd   = m_pc_d;
        n_pc4   = m_pc4_d;
        if (FlushD) begin
            n_instr = 32'h0; n_pcd = 32'h0; n_pc4 = 32'h0;
        end else if (!StallD) begin
            n_instr = InstrF; n_pcd = m_pc; n_pc4 = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr_d = n_instr; m_pc_d = n_pcd; m_pc4_d = n_pc4;
    endtask

    task automatic clear_ctrl();
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks += 5;
        if (PCF !== 32'h0)      begin errors++; $display("FAIL reset_pcf got %h want %h", PCF, 32'h0); end
        if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pcplus4f got %h want %h", PCPlus4F, 32'h4); end
        if (InstrD !== 32'h0)   begin errors++; $display("FAIL reset_instrd got %h want %h", InstrD, 32'h0); end
        if (PCD !== 32'h0)      begin errors++; $display("FAIL reset_pcd got %h want %h", PCD, 32'h0); end
        if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcplus4d got %h want %h", PCPlus4D, 32'h0); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        clear_ctrl();
        InstrF = 32'h00500113;
        tick();
        checks += 4;
        if (PCF !== 32'd4)             begin errors++; $display("FAIL seq1_pcf got %h want %h", PCF, 32'd4); end
        if (InstrD !== 32'h00500113)   begin errors++; $display("FAIL seq1_instrd got %h want %h", InstrD, 32'h00500113); end
        if (PCD !== 32'd0)             begin errors++; $display("FAIL seq1_pcd got %h want %h", PCD, 32'd0); end
        if (PCPlus4D !== 32'd4)        begin errors++; $display("FAIL seq1_pcplus4d got %h want %h", PCPlus4D, 32'd4); end
        InstrF = 32'h00C00193;
        tick();
        InstrF = 32'hFF718393;
        tick();
        checks += 4;
        if (PCF !== 32'd12)            begin errors++; $display("FAIL seq3_pcf got %h want %h", PCF, 32'd12); end
        if (PCD !== 32'd8)             begin errors++; $display("FAIL seq3_pcd got %h want %h", PCD, 32'd8); end
        if (PCPlus4D !== 32'd12)       begin errors++; $display("FAIL seq3_pcplus4d got %h want %h", PCPlus4D, 32'd12); end
        if (InstrD !== 32'hFF718393)   begin errors++; $display("FAIL seq3_instrd got %h want %h", InstrD, 32'hFF718393); end
    endtask

    task automatic test_redirect();
        clear_ctrl();
        PCSrcE = 1'b1; PCTargetE = 32'h8; InstrF = $urandom;
        tick();
        PCTargetE = 32'h100; InstrF = $urandom;
        tick();
        checks += 2;
        if (PCF !== 32'h100) begin errors++; $display("FAIL redir_pcf got %h want %h", PCF, 32'h100); end
        if (PCD !== 32'h8)   begin errors++; $display("FAIL redir_pcd got %h want %h", PCD, 32'h8); end
        PCSrcE = 1'b0; InstrF = $urandom;
        tick();
        checks += 2;
        if (PCD !== 32'h100)      begin errors++; $display("FAIL redir2_pcd got %h want %h", PCD, 32'h100); end
        if (PCPlus4D !== 32'h104) begin errors++; $display("FAIL redir2_pcplus4d got %h want %h", PCPlus4D, 32'h104); end
    endtask

    task automatic test_wrap();
        clear_ctrl();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; InstrF = $urandom;
        tick();
        checks += 1;
        if (PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4f got %h want %h", PCPlus4F, 32'h0); end
        PCSrcE = 1'b0; InstrF = $urandom;
        tick();
        checks += 3;
        if (PCF !== 32'h0)             begin errors++; $display("FAIL wrap_pcf got %h want %h", PCF, 32'h0); end
        if (PCD !== 32'hFFFF_FFFC)     begin errors++; $display("FAIL wrap_pcd got %h want %h", PCD, 32'hFFFF_FFFC); end
        if (PCPlus4D !== 32'h0)        begin errors++; $display("FAIL wrap_pcplus4d got %h want %h", PCPlus4D, 32'h0); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] s_pc, s_instr, s_pcd, s_pc4;
        clear_ctrl();
        InstrF = $urandom;
        tick();
        s_pc = m_pc; s_instr = m_instr_d; s_pcd = m_pc_d; s_pc4 = m_pc4_d;
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            InstrF = $urandom;
            PCSrcE = i[0]; PCTargetE = 32'h200;
            tick();
        end
        checks += 4;
        if (PCF !== s_pc)        begin errors++; $display("FAIL stall_pcf got %h want %h", PCF, s_pc); end
        if (InstrD !== s_instr)  begin errors++; $display("FAIL stall_instrd got %h want %h", InstrD, s_instr); end
        if (PCD !== s_pcd)       begin errors++; $display("FAIL stall_pcd got %h want %h", PCD, s_pcd); end
        if (PCPlus4D !== s_pc4)  begin errors++; $display("FAIL stall_pcplus4d got %h want %h", PCPlus4D, s_pc4); end
        StallF = 1'b0; StallD = 1'b1; FlushD = 1'b1; PCSrcE = 1'b0; InstrF = $urandom;
        tick();
        checks += 4;
        if (PCF !== s_pc + 32'd4) begin errors++; $display("FAIL flush_pcf got %h want %h", PCF, s_pc + 32'd4); end
        if (InstrD !== 32'h0)     begin errors++; $display("FAIL flush_instrd got %h want %h", InstrD, 32'h0); end
        if (PCD !== 32'h0)        begin errors++; $display("FAIL flush_pcd got %h want %h", PCD, 32'h0); end
        if (PCPlus4D !== 32'h0)   begin errors++; $display("FAIL flush_pcplus4d got %h want %h", PCPlus4D, 32'h0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            StallF    = ($urandom_range(0, 3) == 0);
            StallD    = ($urandom_range(0, 3) == 0);
            FlushD    = ($urandom_range(0, 5) == 0);
            PCSrcE    = ($urandom_range(0, 4) == 0);
            PCTargetE = $urandom;
            InstrF    = $urandom;
            tick();
            checks++;
            if (PCF !== m_pc || PCPlus4F !== m_pc + 32'd4 || InstrD !== m_instr_d ||
                PCD !== m_pc_d || PCPlus4D !== m_pc4_d) begin
                errors++;
                $display("FAIL rand_cycle%0d got pcf=%h p4f=%h instr=%h pcd=%h p4d=%h want pcf=%h p4f=%h instr=%h pcd=%h p4d=%h",
                         i, PCF, PCPlus4F, InstrD, PCD, PCPlus4D,
                         m_pc, m_pc + 32'd4, m_instr_d, m_pc_d, m_pc4_d);
            end
        end
        clear_ctrl();
    endtask

    task automatic test_midrun_reset();
        clear_ctrl();
        PCSrcE = 1'b1; PCTargetE = 32'h40; InstrF = $urandom;
        tick();
        PCSrcE = 1'b0;
        checks += 1;
        if (PCF !== 32'h40) begin errors++; $display("FAIL mid_pre_pcf got %h want %h", PCF, 32'h40); end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks += 4;
        if (PCF !== 32'h0)      begin errors++; $display("FAIL mid_reset_pcf got %h want %h", PCF, 32'h0); end
        if (InstrD !== 32'h0)   begin errors++; $display("FAIL mid_reset_instrd got %h want %h", InstrD, 32'h0); end
        if (PCD !== 32'h0)      begin errors++; $display("FAIL mid_reset_pcd got %h want %h", PCD, 32'h0); end
        if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL mid_reset_pcplus4d got %h want %h", PCPlus4D, 32'h0); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        InstrF = $urandom;
        tick();
        checks += 2;
        if (PCF !== 32'h4)      begin errors++; $display("FAIL mid_after_pcf got %h want %h", PCF, 32'h4); end
        if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL mid_after_pcplus4d got %h want %h", PCPlus4D, 32'h4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_wrap();
        test_stall_flush();
        test_random();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
